ps2_scancode_rx: RTL and testbench

PS/2 device-to-host receiver that produces the 16-bit `keyboard_out` scancode word consumed by the keyboard hex-entry logic. It samples the raw `ps2_clk` and `ps2_data` pins, frames 11-bit PS/2 characters, and checks parity, start and stop bits. It then strips break (`F0`) sequences and presents each make code exactly once, for one `clk` cycle, with its `E0` extension prefix.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_scancode_rx_if.sv | 10 +
 rtl/ps2_line_filter.sv | 42 ++++
 rtl/ps2_scancode_rx.sv | 132 +++++++++++++
 tb/tb_ps2_scancode_rx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM state type and status-byte lookup for the PS/2 receiver.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_e;

   // Keyboard status/ack bytes that never represent a key.
   function automatic logic is_status(input logic [7:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
         default:                                        is_status = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// PS/2 pins in, scancode word and error pulse out.
interface ps2_scancode_rx_if;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] keyboard_out;
   logic        frame_err;

   modport master (output ps2_clk, output ps2_data, input keyboard_out, input frame_err);
   modport slave  (input ps2_clk, input ps2_data, output keyboard_out, output frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizer + glitch filter for a slow asynchronous line, with a falling-edge strobe.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic fall
);
   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Two-flop synchronizer against metastability on the raw pin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b00;
      else        sync <= {sync[0], din};
   end

   // Level follows the line only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync[1];
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: frames 11-bit characters and turns make codes
// (with optional E0 prefix) into one-cycle scancode words; break sequences are dropped.
//
// state     | meaning
// ST_IDLE   | waiting for start bit (data=0 on falling clock)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
module ps2_scancode_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input logic            clk,
   input logic            rst_n,
   ps2_scancode_rx_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYC);

   logic          clk_level_unused;
   logic          clk_fall;
   logic [1:0]    data_sync;
   logic          data_s;
   frame_state_e  state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          parity;
   logic [TW-1:0] to_cnt;
   logic          byte_valid;
   logic          fsm_err;
   logic          ext;
   logic          brk;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.ps2_clk),
      .level (clk_level_unused),
      .fall  (clk_fall)
   );

   // Data pin only needs synchronizing; it is sampled long after it settles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_sync <= 2'b00;
      else        data_sync <= {data_sync[0], bus.ps2_data};
   end
   assign data_s = data_sync[1];

   // Frame FSM with inactivity timeout; a fall in the same cycle beats the timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity     <= 1'b0;
         to_cnt     <= '0;
         byte_valid <= 1'b0;
         fsm_err    <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         fsm_err    <= 1'b0;
         if (clk_fall) begin
            to_cnt <= '0;
            case (state)
               ST_IDLE: begin
                  if (!data_s) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                     shreg   <= '0;
                  end else begin
                     fsm_err <= 1'b1;
                  end
               end
               ST_DATA: begin
                  shreg   <= {data_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity <= data_s;
                  state  <= ST_STOP;
               end
               ST_STOP: begin
                  if (data_s && (^{shreg, parity})) byte_valid <= 1'b1;
                  else                              fsm_err    <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state == ST_IDLE) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LIMIT) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            fsm_err <= 1'b1;
            to_cnt  <= '0;
         end else begin
            to_cnt <= to_cnt + TW'(1);
         end
      end
   end

   // Sequence decoder: tracks E0/F0 prefixes and emits make codes once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext              <= 1'b0;
         brk              <= 1'b0;
         bus.keyboard_out <= '0;
         bus.frame_err    <= 1'b0;
      end else begin
         bus.keyboard_out <= '0;
         bus.frame_err    <= fsm_err;
         if (fsm_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_valid) begin
            if (shreg == PS2_EXT) begin
               ext <= 1'b1;
            end else if (shreg == PS2_BRK) begin
               brk <= 1'b1;
            end else begin
               if (!is_status(shreg) && !brk)
                  bus.keyboard_out <= {(ext ? PS2_EXT : 8'h00), shreg};
               ext <= 1'b0;
               brk <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed + randomized bench for ps2_scancode_rx against a byte-level sequence model.
module tb_ps2_scancode_rx;
   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 2000;
   localparam int HALF        = 20;
   localparam int KEY_LAT     = 4 + FILTER_LEN;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   ps2_scancode_rx_if bus ();

   ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed events
   logic [15:0] key_q[$];
   int          lat_q[$];
   int          err_cnt;
   int          last_stop_cyc;

   // Expected events
   logic [15:0] exp_key_q[$];
   int          exp_err;
   int          done_idx;
   bit          ext_m;
   bit          brk_m;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.keyboard_out != 16'h0000) begin
            key_q.push_back(bus.keyboard_out);
            lat_q.push_back(cyc - last_stop_cyc);
         end
         if (bus.frame_err) err_cnt = err_cnt + 1;
      end
   end

   // Byte-level model: what the keyboard sequence means, not how the RTL does it.
   task automatic model_byte(input logic [7:0] b, input bit good);
      if (!good) begin
         exp_err++;
         ext_m = 0;
         brk_m = 0;
      end else if (b == 8'hE0) begin
         ext_m = 1;
      end else if (b == 8'hF0) begin
         brk_m = 1;
      end else begin
         if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) && !brk_m)
            exp_key_q.push_back({(ext_m ? 8'hE0 : 8'h00), b});
         ext_m = 0;
         brk_m = 0;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic v, input bit is_stop);
      @(negedge clk);
      bus.ps2_data = v;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b0;
      if (is_stop) last_stop_cyc = cyc;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
      logic [10:0] fr;
      fr = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(fr[i], i == 10);
      bus.ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      send_bit(1'b0, 0);
      for (int i = 0; i < nbits; i++) send_bit(b[i], 0);
   endtask

   task automatic check_events(input string tag);
      checks++;
      assert (key_q.size() === exp_key_q.size()) else begin
         errors++;
         $error("FAIL %s key_count observed %0d expected %0d", tag, key_q.size(), exp_key_q.size());
      end
      for (int i = done_idx; i < key_q.size() && i < exp_key_q.size(); i++) begin
         checks++;
         assert (key_q[i] === exp_key_q[i]) else begin
            errors++;
            $error("FAIL %s key[%0d] observed %h expected %h", tag, i, key_q[i], exp_key_q[i]);
         end
         checks++;
         assert (lat_q[i] === KEY_LAT) else begin
            errors++;
            $error("FAIL %s latency[%0d] observed %0d expected %0d", tag, i, lat_q[i], KEY_LAT);
         end
      end
      checks++;
      assert (err_cnt === exp_err) else begin
         errors++;
         $error("FAIL %s frame_err_count observed %0d expected %0d", tag, err_cnt, exp_err);
      end
      done_idx = exp_key_q.size();
      if (key_q.size() > done_idx) done_idx = key_q.size();
      // Resynchronize so one miss is not reported again at every later step.
      while (exp_key_q.size() < done_idx) exp_key_q.push_back(16'hxxxx);
      while (key_q.size() < done_idx) begin
         key_q.push_back(16'hxxxx);
         lat_q.push_back(-1);
      end
      exp_err = err_cnt;
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      assert (bus.keyboard_out === 16'h0000) else begin
         errors++;
         $error("FAIL %s keyboard_out observed %h expected 0000", tag, bus.keyboard_out);
      end
      checks++;
      assert (bus.frame_err === 1'b0) else begin
         errors++;
         $error("FAIL %s frame_err observed %b expected 0", tag, bus.frame_err);
      end
   endtask

   initial begin
      logic [7:0] b;
      bit         pbad;
      bit         sbad;
      int         r;
      cyc = 0; checks = 0; errors = 0; err_cnt = 0; exp_err = 0;
      done_idx = 0; last_stop_cyc = 0; ext_m = 0; brk_m = 0;
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      rst_n = 1'b0;
      wait_cyc(5);
      check_idle_outputs("in_reset");
      rst_n = 1'b1;
      wait_cyc(20);
      check_idle_outputs("after_reset");

      // Make then break of one key
      send_frame(8'h1C, 0, 0); model_byte(8'h1C, 1);
      send_frame(8'hF0, 0, 0); model_byte(8'hF0, 1);
      send_frame(8'h1C, 0, 0); model_byte(8'h1C, 1);
      check_events("make_break");

      // Extended make then extended break
      send_frame(8'hE0, 0, 0); model_byte(8'hE0, 1);
      send_frame(8'h74, 0, 0); model_byte(8'h74, 1);
      send_frame(8'hE0, 0, 0); model_byte(8'hE0, 1);
      send_frame(8'hF0, 0, 0); model_byte(8'hF0, 1);
      send_frame(8'h74, 0, 0); model_byte(8'h74, 1);
      check_events("extended");

      // Parity error then good byte
      send_frame(8'h5A, 1, 0); model_byte(8'h5A, 0);
      check_events("parity_err");
      send_frame(8'h5A, 0, 0); model_byte(8'h5A, 1);
      check_events("after_parity_err");

      // Bad stop bit after E0 must also drop the prefix
      send_frame(8'hE0, 0, 0); model_byte(8'hE0, 1);
      send_frame(8'h29, 0, 1); model_byte(8'h29, 0);
      send_frame(8'h29, 0, 0); model_byte(8'h29, 1);
      check_events("stop_err");

      // Lone clock pulse with data high is a bad start bit
      send_bit(1'b1, 0);
      wait_cyc(2 * HALF);
      model_byte(8'h00, 0);
      check_events("start_err");

      // Short low glitch on the clock with data low must not start a frame
      @(negedge clk);
      bus.ps2_data = 1'b0;
      bus.ps2_clk = 1'b0;
      wait_cyc(3);
      bus.ps2_clk = 1'b1;
      wait_cyc(HALF);
      bus.ps2_data = 1'b1;
      wait_cyc(HALF);
      check_events("glitch");

      // Partial frame stalls beyond the timeout
      send_partial(8'h33, 4);
      wait_cyc(TIMEOUT_CYC + 100);
      model_byte(8'h00, 0);
      check_events("timeout");
      send_frame(8'h16, 0, 0); model_byte(8'h16, 1);
      check_events("after_timeout");

      // Status byte produces nothing
      send_frame(8'hAA, 0, 0); model_byte(8'hAA, 1);
      check_events("status_aa");

      // Reset in the middle of a frame, with a pending E0 prefix
      send_frame(8'hE0, 0, 0);
      send_partial(8'h45, 3);
      @(negedge clk);
      rst_n = 1'b0;
      ext_m = 0;
      brk_m = 0;
      wait_cyc(3);
      check_idle_outputs("mid_frame_reset");
      rst_n = 1'b1;
      wait_cyc(2 * HALF);
      check_idle_outputs("after_mid_reset");
      send_frame(8'h45, 0, 0); model_byte(8'h45, 1);
      check_events("after_reset_45");

      // Random keyboard traffic
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      b = 8'hE0;
         else if (r == 1) b = 8'hF0;
         else if (r == 2) begin
            r = $urandom_range(0, 6);
            case (r)
               0: b = 8'h00; 1: b = 8'hAA; 2: b = 8'hEE; 3: b = 8'hFA;
               4: b = 8'hFC; 5: b = 8'hFE; default: b = 8'hFF;
            endcase
         end else b = 8'($urandom_range(0, 255));
         pbad = ($urandom_range(0, 11) == 0);
         sbad = ($urandom_range(0, 11) == 0);
         send_frame(b, pbad, sbad);
         model_byte(b, !(pbad || sbad));
         check_events("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
